// File: rtl/dff_chk_pkg.sv
// Shared types and defaults for the dff_scoreboard response checker.
// Holds the checker FSM encoding and the saturating counter helper.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FAULT
    } chk_state_e;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // Counter widths up to 64 bits share this one helper.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int unsigned w
    );
        logic [63:0] max;
        max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max) ? max : v + 64'd1;
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// Circular expected-value queue for the response checker.
// Caller guarantees legal push/pop; no error handling here.
module chk_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/dff_scoreboard.sv
// Response checker: pops one expected value per observed DUT output,
// counts matches/mismatches and latches the first mismatch.
module dff_scoreboard
    import dff_chk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     exp_valid,
    input  logic [WIDTH-1:0]         exp_data,
    input  logic                     obs_valid,
    input  logic [WIDTH-1:0]         obs_data,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         mismatch_cnt,
    output logic                     err,
    output logic [WIDTH-1:0]         first_exp,
    output logic [WIDTH-1:0]         first_obs,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     idle
);

    localparam int PW = $clog2(DEPTH) + 1;

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_obs_q, first_obs_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             idle_q, idle_d;

    logic             fault;
    logic             push_req, pop_req;
    logic             ovf_ev, unf_ev;
    logic             push_en, pop_en;
    logic [WIDTH-1:0] head;
    logic [PW-1:0]    fifo_cnt, nxt_cnt;
    logic             fifo_full, fifo_empty;

    chk_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push_en),
        .pop   (pop_en),
        .wdata (exp_data),
        .rdata (head),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        err_d          = err_q;
        first_exp_d    = first_exp_q;
        first_obs_d    = first_obs_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;

        fault    = (state_q == FAULT);
        push_req = exp_valid && !fault;
        pop_req  = obs_valid && !fault;
        // A pop on a full queue frees the slot the push needs.
        ovf_ev   = push_req && fifo_full && !pop_req;
        unf_ev   = pop_req && fifo_empty;
        push_en  = push_req && !ovf_ev;
        pop_en   = pop_req && !fifo_empty;

        nxt_cnt = fifo_cnt;
        if (push_en && !pop_en) begin
            nxt_cnt = fifo_cnt + 1'b1;
        end else if (pop_en && !push_en) begin
            nxt_cnt = fifo_cnt - 1'b1;
        end

        if (pop_en) begin
            if (head == obs_data) begin
                match_cnt_d = CNT_W'(sat_inc(64'(match_cnt_q), CNT_W));
            end else begin
                mismatch_cnt_d = CNT_W'(sat_inc(64'(mismatch_cnt_q), CNT_W));
                err_d          = 1'b1;
                if (mismatch_cnt_q == '0) begin
                    first_exp_d = head;
                    first_obs_d = obs_data;
                end
            end
        end

        if (ovf_ev) begin
            overflow_d = 1'b1;
            err_d      = 1'b1;
        end
        if (unf_ev) begin
            underflow_d = 1'b1;
            err_d       = 1'b1;
        end

        if (fault || ovf_ev || unf_ev) begin
            state_d = FAULT;
        end else if (nxt_cnt == '0) begin
            state_d = EMPTY;
        end else begin
            state_d = BUSY;
        end

        if (clr) begin
            state_d        = EMPTY;
            match_cnt_d    = '0;
            mismatch_cnt_d = '0;
            err_d          = 1'b0;
            first_exp_d    = '0;
            first_obs_d    = '0;
            overflow_d     = 1'b0;
            underflow_d    = 1'b0;
        end

        idle_d = (state_d == EMPTY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= EMPTY;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            err_q          <= 1'b0;
            first_exp_q    <= '0;
            first_obs_q    <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            idle_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            err_q          <= err_d;
            first_exp_q    <= first_exp_d;
            first_obs_q    <= first_obs_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            idle_q         <= idle_d;
        end
    end

    assign match_cnt    = match_cnt_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign err          = err_q;
    assign first_exp    = first_exp_q;
    assign first_obs    = first_obs_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign pending      = fifo_cnt;
    assign idle         = idle_q;

endmodule

// File: tb/tb_dff_scoreboard.sv
// Bench for dff_scoreboard: a model queue holds pushed values and
// supplies the expected verdicts when observed values are applied.
module tb_dff_scoreboard;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_data;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             err;
    logic [WIDTH-1:0] first_exp;
    logic [WIDTH-1:0] first_obs;
    logic             overflow;
    logic             underflow;
    logic [PW-1:0]    pending;
    logic             idle;

    dff_scoreboard #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data),
        .obs_valid    (obs_valid),
        .obs_data     (obs_data),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .err          (err),
        .first_exp    (first_exp),
        .first_obs    (first_obs),
        .overflow     (overflow),
        .underflow    (underflow),
        .pending      (pending),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_q[$];
    int               m_match;
    int               m_mis;
    logic             m_err;
    logic             m_ovf;
    logic             m_unf;
    logic             m_fault;
    logic [WIDTH-1:0] m_fexp;
    logic [WIDTH-1:0] m_fobs;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_match = 0;
        m_mis   = 0;
        m_err   = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_fault = 1'b0;
        m_fexp  = '0;
        m_fobs  = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pending"}, 32'(pending), 32'(m_q.size()));
        chk({tag, ".idle"}, 32'(idle), 32'(!m_fault && m_q.size() == 0));
        chk({tag, ".match"}, 32'(match_cnt), 32'(m_match));
        chk({tag, ".mismatch"}, 32'(mismatch_cnt), 32'(m_mis));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        chk({tag, ".fexp"}, 32'(first_exp), 32'(m_fexp));
        chk({tag, ".fobs"}, 32'(first_obs), 32'(m_fobs));
    endtask

    // One clock with optional push/pop; model advances with the edge.
    task automatic step(input string tag, input logic p,
                        input logic [WIDTH-1:0] pd, input logic o,
                        input logic [WIDTH-1:0] od);
        logic             ovf;
        logic             unf;
        logic [WIDTH-1:0] h;
        exp_valid = p;
        exp_data  = pd;
        obs_valid = o;
        obs_data  = od;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        obs_valid = 1'b0;
        if (!m_fault) begin
            ovf = p && (m_q.size() == DEPTH) && !o;
            unf = o && (m_q.size() == 0);
            if (o && m_q.size() > 0) begin
                h = m_q.pop_front();
                if (h == od) begin
                    m_match++;
                end else begin
                    if (m_mis == 0) begin
                        m_fexp = h;
                        m_fobs = od;
                    end
                    m_mis++;
                    m_err = 1'b1;
                end
            end
            if (p && !ovf) m_q.push_back(pd);
            if (ovf) m_ovf = 1'b1;
            if (unf) m_unf = 1'b1;
            if (ovf || unf) begin
                m_err   = 1'b1;
                m_fault = 1'b1;
            end
        end
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [WIDTH-1:0] v);
        step(tag, 1'b1, v, 1'b0, '0);
    endtask

    task automatic pop_ok(input string tag);
        step(tag, 1'b0, '0, 1'b1, m_q[0]);
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        rst       = 1'b0;
        clr       = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        obs_valid = 1'b0;
        obs_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        push("in3", 4'h3);
        push("inA", 4'hA);
        push("in5", 4'h5);
        step("ob3", 1'b0, '0, 1'b1, 4'h3);
        step("obA", 1'b0, '0, 1'b1, 4'hA);
        step("ob5", 1'b0, '0, 1'b1, 4'h5);

        push("in9", 4'h9);
        step("ob8", 1'b0, '0, 1'b1, 4'h8);
        push("in1", 4'h1);
        step("ob0", 1'b0, '0, 1'b1, 4'h0);

        do_clr("clr1");
        for (int i = 0; i < DEPTH; i++) begin
            push("fill", 4'(i + 2));
        end
        step("full_pp", 1'b1, 4'hE, 1'b1, m_q[0]);
        push("ovf", 4'hF);
        pop_ok("frozen1");
        pop_ok("frozen2");
        push("frozen3", 4'h1);

        do_clr("clr2");
        step("unf", 1'b1, 4'h7, 1'b1, 4'h0);
        step("unf_hold", 1'b0, '0, 1'b1, 4'h7);

        do_clr("clr3");
        for (int i = 0; i < 4; i++) begin
            v = 4'($urandom_range(0, 15));
            push("wrap_in", v);
        end
        for (int i = 0; i < 8; i++) begin
            v = 4'($urandom_range(0, 15));
            step("wrap_pp", 1'b1, v, 1'b1, m_q[0]);
        end
        for (int i = 0; i < 4; i++) begin
            pop_ok("wrap_out");
        end
        chk("wrap_total", 32'(match_cnt), 32'd12);

        for (int i = 0; i < 5; i++) begin
            push("pre_rst", 4'(i + 9));
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst");

        pop_ok("post_rst_push");
        step("to_fault", 1'b0, '0, 1'b1, 4'h2);
        do_clr("clr_fault");
        push("after_clr", 4'hC);
        pop_ok("after_clr_pop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dff_scoreboard.md
# dff_scoreboard

Synthesizable response checker for register-style DUTs such as the 4-bit DFF blocks. It is the consuming end of the stimulus/response path. The stimulus side pushes each value it drives into an expected-value queue, and the block pops one entry per observed DUT output and compares the two. It keeps match and mismatch counters, a sticky error flag and a capture of the first mismatch, so a bench or on-chip self-test can read a pass/fail verdict without software-side queues.

## Interface
- `WIDTH`, 4, data width of the expected and observed values
- `DEPTH`, 8, expected-queue depth in entries; must be a power of two, at least 2
- `CNT_W`, 16, width of the match and mismatch counters
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous assert, active-low
- `clr`  in  1  synchronous clear of queue, counters, flags and FSM; has priority over all other inputs
- `exp_valid`  in  1  push `exp_data` into the expected queue this cycle
- `exp_data`  in  WIDTH  expected value
- `obs_valid`  in  1  pop the queue head and compare it with `obs_data` this cycle
- `obs_data`  in  WIDTH  observed DUT output
- `match_cnt`  out  CNT_W  number of compares that matched; saturating
- `mismatch_cnt`  out  CNT_W  number of compares that mismatched; saturating
- `err`  out  1  sticky: set by any mismatch, overflow or underflow
- `first_exp`  out  WIDTH  expected value of the first mismatch
- `first_obs`  out  WIDTH  observed value of the first mismatch
- `overflow`  out  1  sticky: a push was attempted while the queue was full with no pop
- `underflow`  out  1  sticky: a pop was attempted while the queue was empty
- `pending`  out  $clog2(DEPTH)+1  current queue occupancy
- `idle`  out  1  high when state is EMPTY

## Operation
- FSM states:
  - EMPTY: `pending` is 0.
  - BUSY: 0 < `pending` ≤ DEPTH.
  - FAULT: entered on overflow or underflow. Exit only via `clr` or reset.
- FSM transitions:
  - EMPTY→BUSY on a push.
  - BUSY→EMPTY when the last entry is popped and there is no push in the same cycle.
  - Any state→FAULT on an overflow or underflow condition.
- Push and pop in the same cycle while BUSY: both take effect, `pending` is unchanged. This also applies when full.
- Push while full with no pop: the data is dropped, `overflow` and `err` are set, state goes to FAULT.
- Pop while empty: no comparison is made, counters are unchanged, `underflow` and `err` are set, state goes to FAULT. There is no bypass, so a same-cycle push does not satisfy the pop; the push is still enqueued.
- In FAULT: pushes, pops and compares are ignored, so the counters freeze.
- Compare rule: the queue head is compared with `obs_data` using a full `WIDTH`-bit equality.
  - Equal: `match_cnt` increments.
  - Not equal: `mismatch_cnt` increments and `err` is set.
  - On the first mismatch only, `first_exp` and `first_obs` are latched and then held.
- Counters saturate at all ones.
- Queue order is FIFO, so the oldest push is compared first. Read and write pointers wrap modulo `DEPTH`.

## Timing
- Reset and `clr` values:
  - All counters, `first_exp` and `first_obs` are 0.
  - `err`, `overflow`, `underflow` are 0.
  - `pending` is 0, `idle` is 1, state is EMPTY.
- Reset asserts asynchronously and takes effect mid-operation with no residual state; release is synchronous to `clk`.
- Compare latency is 1 cycle: with `obs_valid` high at edge n, the counters, `err` and the first-mismatch capture update at edge n and are visible in cycle n+1.
- `pending` and `idle` update at the same edge as the push or pop that changes them.
- Pushed data can be popped no earlier than the cycle after it is written. Expected latency therefore pairs naturally with a DFF sampled one edge later.

## Structure
- Package `dff_chk_pkg` holds:
  - the `chk_state_e` enum (EMPTY, BUSY, FAULT);
  - default `WIDTH`, `DEPTH` and `CNT_W` localparams;
  - a saturating-increment function.
- Sub-module `chk_fifo` is a synchronous FIFO with circular storage, a `count`, and `full`/`empty` flags; it does no error handling.
- The top level holds the FSM, the compare logic, the counters and the sticky flags.

## Test plan
- Reset, then push 4'h3, 4'hA, 4'h5 and pop with `obs_data` 3, A, 5 → `match_cnt`=3, `mismatch_cnt`=0, `err`=0, `idle`=1.
- Push 4'h9, pop with 4'h8, then push 4'h1, pop with 4'h0 → `mismatch_cnt`=2, `err`=1, `first_exp`=9, `first_obs`=8 (unchanged by the second mismatch).
- Fill 8 entries, then push and pop in the same cycle → `pending` stays 8, no `overflow`. A ninth push with no pop → `overflow`=1, state FAULT, and later pops leave the counters unchanged.
- Pop from empty in the same cycle as a push of 4'h7 → `underflow`=1, `pending`=1, counters stay 0.
- Push 12 values with interleaved pops so the pointers wrap, all observed values correct → 12 matches and FIFO order preserved.
- Drop `rst` low mid-stream with `pending`=5 → all outputs immediately show their reset values. Assert `clr` in FAULT → state returns to EMPTY and the flags clear.
